// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer: pops PS/2 scan-code bytes from the receiver FIFO, folds E0 (extended) and
// F0 (break) prefixes into single key events, and presents them on a valid/ready handshake.
// Also tracks the currently held key, a make-event counter and a sticky FIFO overflow flag.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ready, overflow, data FIFO status and head byte
//   nextdata_n            active-low one-cycle pop strobe to the FIFO
//   evt_valid/evt_ready   event handshake; evt_code/evt_ext/evt_break carry the event
//   held_valid/code/ext   currently held key
//   press_count           accepted make events, mod 256
//   ovf_sticky, clear_ovf sticky overflow flag and its clear
module ps2_key_sequencer #(
  parameter int unsigned DROP_REPEAT    = 1,
  parameter int unsigned PREFIX_TIMEOUT = 50000,
  parameter int unsigned TO_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ready,
  input  logic       overflow,
  input  logic [7:0] data,
  output logic       nextdata_n,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       held_valid,
  output logic [7:0] held_code,
  output logic       held_ext,
  output logic [7:0] press_count,
  output logic       ovf_sticky,
  input  logic       clear_ovf
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StPop  = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;
  localparam logic [1:0] StEmit = 2'd3;

  localparam logic [7:0]      CodeExt = 8'hE0;
  localparam logic [7:0]      CodeBrk = 8'hF0;
  localparam logic [TO_W-1:0] ToLimit = TO_W'(PREFIX_TIMEOUT);

  logic [1:0]      state_q, state_d;
  logic [7:0]      byte_q, byte_d;
  logic            ext_pend_q, ext_pend_d;
  logic            brk_pend_q, brk_pend_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            nextdata_n_q, nextdata_n_d;
  logic            evt_valid_q, evt_valid_d;
  logic [7:0]      evt_code_q, evt_code_d;
  logic            evt_ext_q, evt_ext_d;
  logic            evt_break_q, evt_break_d;
  logic            held_valid_q, held_valid_d;
  logic [7:0]      held_code_q, held_code_d;
  logic            held_ext_q, held_ext_d;
  logic [7:0]      press_count_q, press_count_d;
  logic            ovf_q, ovf_d;

  logic            is_repeat;
  logic            evt_matches_held;
  logic [TO_W-1:0] to_cnt_inc;

  // Typematic repeat: a make of the key that is already held.
  assign is_repeat = (DROP_REPEAT != 0) && !brk_pend_q && held_valid_q &&
                     (ext_pend_q == held_ext_q) && (byte_q == held_code_q);
  assign evt_matches_held = (evt_ext_q == held_ext_q) && (evt_code_q == held_code_q);
  assign to_cnt_inc = to_cnt_q + TO_W'(1);

  always_comb begin
    state_d       = state_q;
    byte_d        = byte_q;
    ext_pend_d    = ext_pend_q;
    brk_pend_d    = brk_pend_q;
    to_cnt_d      = '0;
    nextdata_n_d  = 1'b1;
    evt_valid_d   = evt_valid_q;
    evt_code_d    = evt_code_q;
    evt_ext_d     = evt_ext_q;
    evt_break_d   = evt_break_q;
    held_valid_d  = held_valid_q;
    held_code_d   = held_code_q;
    held_ext_d    = held_ext_q;
    press_count_d = press_count_q;
    // Set wins over clear.
    ovf_d         = overflow ? 1'b1 : (clear_ovf ? 1'b0 : ovf_q);

    case (state_q)
      StIdle: begin
        if (ready) begin
          byte_d       = data;
          nextdata_n_d = 1'b0;
          state_d      = StPop;
        end else if (ext_pend_q || brk_pend_q) begin
          // A prefix left dangling too long is stale; drop it.
          if (to_cnt_inc == ToLimit) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
          end else begin
            to_cnt_d = to_cnt_inc;
          end
        end
        if (overflow) begin
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end
      end
      StPop: begin
        state_d = StGap;
        if (byte_q == CodeExt) begin
          ext_pend_d = 1'b1;
        end else if (byte_q == CodeBrk) begin
          brk_pend_d = 1'b1;
        end else begin
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
          if (!is_repeat) begin
            evt_valid_d = 1'b1;
            evt_code_d  = byte_q;
            evt_ext_d   = ext_pend_q;
            evt_break_d = brk_pend_q;
            state_d     = StEmit;
          end
        end
      end
      StGap: begin
        // Bubble so ready reflects the FIFO after the pop.
        state_d = StIdle;
      end
      StEmit: begin
        if (evt_ready) begin
          evt_valid_d = 1'b0;
          state_d     = StGap;
          if (!evt_break_q) begin
            held_valid_d  = 1'b1;
            held_code_d   = evt_code_q;
            held_ext_d    = evt_ext_q;
            press_count_d = press_count_q + 8'd1;
          end else if (held_valid_q && evt_matches_held) begin
            held_valid_d = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      byte_q        <= '0;
      ext_pend_q    <= 1'b0;
      brk_pend_q    <= 1'b0;
      to_cnt_q      <= '0;
      nextdata_n_q  <= 1'b1;
      evt_valid_q   <= 1'b0;
      evt_code_q    <= '0;
      evt_ext_q     <= 1'b0;
      evt_break_q   <= 1'b0;
      held_valid_q  <= 1'b0;
      held_code_q   <= '0;
      held_ext_q    <= 1'b0;
      press_count_q <= '0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_q        <= byte_d;
      ext_pend_q    <= ext_pend_d;
      brk_pend_q    <= brk_pend_d;
      to_cnt_q      <= to_cnt_d;
      nextdata_n_q  <= nextdata_n_d;
      evt_valid_q   <= evt_valid_d;
      evt_code_q    <= evt_code_d;
      evt_ext_q     <= evt_ext_d;
      evt_break_q   <= evt_break_d;
      held_valid_q  <= held_valid_d;
      held_code_q   <= held_code_d;
      held_ext_q    <= held_ext_d;
      press_count_q <= press_count_d;
      ovf_q         <= ovf_d;
    end
  end

  assign nextdata_n  = nextdata_n_q;
  assign evt_valid   = evt_valid_q;
  assign evt_code    = evt_code_q;
  assign evt_ext     = evt_ext_q;
  assign evt_break   = evt_break_q;
  assign held_valid  = held_valid_q;
  assign held_code   = held_code_q;
  assign held_ext    = held_ext_q;
  assign press_count = press_count_q;
  assign ovf_sticky  = ovf_q;

endmodule

// File: doc/ps2_key_sequencer.md
Name: ps2_key_sequencer

Overview:
- Controller between the PS/2 receiver FIFO (ready/overflow/data/nextdata_n) and the display/counter logic.
- Pops one byte at a time and folds E0/F0 prefixes into single key events.
- Presents each event on a valid/ready handshake.
- Tracks the currently held key and a make-event count for the hex display.

Parameters:
- DROP_REPEAT, 1: when 1, a make of the currently held key (typematic repeat) is consumed but not emitted or counted.
- PREFIX_TIMEOUT, 50000: idle cycles after which a pending E0/F0 prefix is discarded.
- TO_W, 16: width of the prefix timeout counter; PREFIX_TIMEOUT < 2^TO_W.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- ready  in  1  FIFO non-empty
- overflow  in  1  FIFO overflow flag
- data  in  8  FIFO head byte, valid when ready=1
- nextdata_n  out  1  active-low pop strobe to FIFO
- evt_valid  out  1  event available
- evt_ready  in  1  consumer accepts event
- evt_code  out  8  scan code (prefixes stripped)
- evt_ext  out  1  event carried E0 prefix
- evt_break  out  1  event carried F0 prefix (key release)
- held_valid  out  1  a key is currently held
- held_code  out  8  code of held key
- held_ext  out  1  extended flag of held key
- press_count  out  8  accepted make events, mod 256
- ovf_sticky  out  1  overflow seen since last clear
- clear_ovf  in  1  clears ovf_sticky

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; nextdata_n=1.
  - evt_valid=0; evt_code=0, evt_ext=0, evt_break=0.
  - held_valid=0, held_code=0, held_ext=0.
  - press_count=0, ovf_sticky=0.
  - Prefix flags ext_pend and brk_pend cleared; timeout counter cleared.
  - Reset mid-operation aborts any pending pop or event. No partial event survives.
- All outputs are registered.
- FSM states: IDLE, POP, GAP, EMIT.
- IDLE:
  - If ready=1: latch data into byte_q, drive nextdata_n=0 for the next cycle, go to POP.
  - Otherwise stay in IDLE.
- POP:
  - nextdata_n is low for exactly this one cycle, then returns to 1.
  - byte_q=E0: set ext_pend, go to GAP.
  - byte_q=F0: set brk_pend, go to GAP.
  - Any other byte: form event {ext_pend, brk_pend, byte_q}, clear both prefix flags.
    - Drop the event if it is a repeat: DROP_REPEAT=1, brk=0, held_valid=1 and {ext,code}=={held_ext,held_code}. Go to GAP.
    - Otherwise load evt_* and go to EMIT.
- GAP: one bubble cycle so ready reflects the post-pop FIFO. Go to IDLE. Back-to-back bytes therefore take 3 cycles each minimum.
- EMIT:
  - evt_valid=1; evt_* held stable until accepted.
  - No FIFO pops occur while in EMIT (backpressure).
  - On evt_ready=1: evt_valid=0 next cycle, go to GAP, and update tracking:
    - Make event: held_valid=1, held_code/held_ext set to the event, press_count+1 (wraps 255->0).
    - Break event matching held {ext,code}: held_valid=0; held_code and held_ext retain their value.
    - Break event not matching held: no change.
- Prefix timeout:
  - Counter runs only while (ext_pend|brk_pend) and state=IDLE and ready=0. It resets otherwise.
  - On reaching PREFIX_TIMEOUT: clear both flags and the counter.
- Overflow:
  - overflow=1 in any cycle sets ovf_sticky.
  - clear_ovf=1 clears it; if both occur in the same cycle, set wins.
  - overflow=1 while in IDLE also clears ext_pend and brk_pend (the stream is no longer trustworthy).
  - Pops continue normally.
- Duplicate prefixes: E0 E0 or F0 F0 simply keep the flag set. F0 then E0 gives both flags set (order-insensitive).

Test Plan:
- Bytes 1C, F0, 1C with evt_ready=1 -> events {0,0,1C} then {0,1,1C}. press_count=1, held_valid 1 then 0. Exactly three single-cycle nextdata_n low pulses, each followed by at least 2 high cycles.
- Bytes E0, 75, E0, F0, 75 -> events {ext=1,brk=0,75} and {ext=1,brk=1,75}. No event is emitted for prefix bytes. held_ext=1 while held.
- Bytes 1C, 1C, 1C, F0, 1C with DROP_REPEAT=1 -> two events only, press_count=1. With DROP_REPEAT=0 -> four events, press_count=3.
- evt_ready=0 for 20 cycles with ready=1 -> evt_valid stays 1, evt_* stable, nextdata_n stays 1. Releasing evt_ready resumes popping.
- F0 followed by PREFIX_TIMEOUT idle cycles, then 1C -> make event {0,0,1C}, not a break. overflow pulse sets ovf_sticky; clear_ovf in the same cycle as overflow leaves it 1, and a later clear_ovf alone clears it.
- 255 make/break pairs of distinct codes plus one more make -> press_count wraps to 00. Asserting rst_n=0 during EMIT -> evt_valid=0, nextdata_n=1, all counters 0 immediately.
